// File: rtl/matrix_dma_sequencer_if.sv
// Avalon-MM burst read master bundle used by matrix_dma_sequencer.
// Handshake: a command (address/burstcount) is accepted when read && !waitrequest; while read && waitrequest the master holds read, address and burstcount stable; readdatavalid returns one word per cycle, in command order.
interface matrix_dma_sequencer_if;
  logic [29:0] address;
  logic        read;
  logic [2:0]  burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/matrix_dma_sequencer.sv
// Burst read sequencer: fetches an NxN matrix over Avalon-MM into matrix RAM (row stride 32).
// Optional stall counter enabled by defining DMA_PERF_CNT_EN; otherwise stall_cycles is tied to 0.
module matrix_dma_sequencer #(
  parameter int BURST           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_ptr,
  input  logic [5:0]  mx_size,
  output logic        busy,
  output logic        done,
  matrix_dma_sequencer_if.master av,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_we,
  output logic [15:0] stall_cycles,
  output logic [1:0]  dbg_state
);

  localparam logic [10:0] BURST_W   = 11'(BURST);
  localparam logic [10:0] MAX_OUT_W = 11'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  n_lat;
  logic [10:0] total;
  logic [10:0] issued;
  logic [10:0] outstanding;
  logic [10:0] received;
  logic [4:0]  row;
  logic [4:0]  col;

  logic [5:0]  n_in;
  logic [10:0] total_in;
  logic [2:0]  first_b;
  logic        accept;
  logic        beat;
  logic [10:0] issued_nx;
  logic [10:0] out_inc;
  logic [10:0] out_nx;
  logic [10:0] remain_nx;
  logic [2:0]  b_nx;
  logic        fits;
  logic        unused_ptr_bits;

  assign dbg_state       = state;
  assign unused_ptr_bits = ^base_ptr[31:30];

  // Next-command decision uses the post-edge issued/outstanding counts so the
  // registered read reflects the limit exactly one cycle later.
  always_comb begin
    n_in      = (mx_size > 6'd32) ? 6'd32 : mx_size;
    total_in  = 11'(n_in) * 11'(n_in);
    first_b   = (total_in < BURST_W) ? total_in[2:0] : BURST_W[2:0];
    accept    = av.read && !av.waitrequest;
    beat      = av.readdatavalid && (state != IDLE);
    issued_nx = accept ? issued + 11'(av.burstcount) : issued;
    out_inc   = accept ? outstanding + 11'(av.burstcount) : outstanding;
    out_nx    = (beat && (out_inc != 11'd0)) ? out_inc - 11'd1 : out_inc;
    remain_nx = total - issued_nx;
    b_nx      = (remain_nx < BURST_W) ? remain_nx[2:0] : BURST_W[2:0];
    fits      = (out_nx + 11'(b_nx)) <= MAX_OUT_W;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      av.address    <= '0;
      av.read       <= 1'b0;
      av.burstcount <= '0;
      ram_addr      <= '0;
      ram_data      <= '0;
      ram_we        <= 1'b0;
      n_lat         <= '0;
      total         <= '0;
      issued        <= '0;
      outstanding   <= '0;
      received      <= '0;
      row           <= '0;
      col           <= '0;
    end else begin
      done   <= 1'b0;
      ram_we <= 1'b0;

      if (beat) begin
        ram_we   <= 1'b1;
        ram_data <= av.readdata;
        ram_addr <= {row, col};
        received <= received + 11'd1;
        if ({1'b0, col} == n_lat - 6'd1) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end

      if (state != IDLE) outstanding <= out_nx;

      case (state)
        IDLE: begin
          if (start) begin
            n_lat       <= n_in;
            total       <= total_in;
            issued      <= '0;
            outstanding <= '0;
            received    <= '0;
            row         <= '0;
            col         <= '0;
            busy        <= 1'b1;
            if (n_in == 6'd0) begin
              state <= FINISH;
            end else begin
              state         <= ISSUE;
              av.read       <= 1'b1;
              av.address    <= base_ptr[29:0];
              av.burstcount <= first_b;
            end
          end
        end

        ISSUE: begin
          // A stalled command stays frozen; everything else re-evaluates.
          if (!(av.read && av.waitrequest)) begin
            issued <= issued_nx;
            if (accept) av.address <= av.address + {25'd0, av.burstcount, 2'b00};
            if (remain_nx == 11'd0) begin
              av.read <= 1'b0;
              state   <= DRAIN;
            end else begin
              av.read       <= fits;
              av.burstcount <= b_nx;
            end
          end
        end

        DRAIN: begin
          if (received == total) state <= FINISH;
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (av.read && av.waitrequest && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/matrix_dma_sequencer.md
Name: matrix_dma_sequencer

Overview:
Avalon-MM burst read sequencer that fetches an N×N matrix of 32-bit words from system memory into the on-chip matrix RAM (row stride 32 words). It sits between the determinant CPU interface, which supplies the start/pointer/size, and the matrix RAM write port. It owns the Avalon master and handles:
- burst splitting,
- waitrequest stalls,
- the outstanding-read limit,
- row/column address generation.

Parameters:
BURST, 4, maximum words per burst command (1..4).
MAX_OUTSTANDING, 8, maximum words requested but not yet returned (≥ BURST).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin a transfer
base_ptr  in  32  byte address of element (0,0); word aligned
mx_size  in  6  matrix dimension N
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
address  out  30  Avalon master address
read  out  1  Avalon read request
burstcount  out  3  Avalon burst length
waitrequest  in  1  Avalon stall
readdata  in  32  Avalon return data
readdatavalid  in  1  Avalon return strobe
ram_addr  out  10  matrix RAM address, row*32+col
ram_data  out  32  matrix RAM write data
ram_we  out  1  matrix RAM write enable
stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous, so read drops immediately mid-transfer; later readdatavalid beats are ignored.
- Size handling: N = min(mx_size, 32); total = N*N (11 bits).
- Start latching: start is accepted only in IDLE. base_ptr and N are latched on acceptance. start while busy is ignored.
- States: IDLE -> ISSUE -> DRAIN -> FINISH -> IDLE.
- IDLE, start with N=0: go directly to FINISH. No read is issued.
- IDLE, start with N>0: go to ISSUE. read, address = base_ptr>>0 (byte address bits [29:0]) and burstcount are valid the cycle after start.
- ISSUE, burst length: b = min(BURST, total − issued).
- ISSUE, outstanding limit: a command is presented only when outstanding + b ≤ MAX_OUTSTANDING. Otherwise read=0.
- ISSUE, stalls: while read && waitrequest, address, burstcount and read hold stable.
- ISSUE, acceptance: a command is accepted on read && !waitrequest. Then issued += b, outstanding += b, address += 4*b.
- ISSUE -> DRAIN when issued reaches total after an accepted command. read=0 in the next cycle.
- Outstanding count: decrements by 1 per readdatavalid. A simultaneous accept and valid nets to +b−1.
- RAM write, any non-IDLE state: readdatavalid registers readdata into ram_data and ram_addr = row*32+col, with ram_we=1 the following cycle (latency 1).
- Column/row advance: after each beat, col increments. At col == N−1, col wraps to 0 and row increments.
- DRAIN -> FINISH when received == total, i.e. the cycle the final ram_we is driven.
- FINISH: done=1 for one cycle; busy falls in the same cycle. Then IDLE.
- Spurious readdatavalid in IDLE produces no ram_we.
- Unused Avalon master fields are driven: address changes only on acceptance.

Optional Feature:
Macro DMA_PERF_CNT_EN.
- Defined: stall_cycles counts cycles with read && waitrequest. It saturates at 16'hFFFF, clears on an accepted start, and holds after done until the next start.
- Undefined: no counter logic; stall_cycles is tied to 0.

Test Plan:
- N=2, base_ptr=0x1000, no waitrequest, data returned 2 cycles after accept -> one burst (burstcount=1..4), then ram writes to addrs 0,1,32,33 with the matching data. done pulses once; busy low afterwards.
- N=5, BURST=4 -> commands at 0x...,+16,... ; 6 bursts of 4 then 1 burst of 1 (25 words). Last ram_addr = 4*32+4 = 132.
- N=3, waitrequest high 3 cycles on the first command -> address/burstcount/read held constant over those cycles. Data lands in addresses 0,1,2,32..34,64..66. With DMA_PERF_CNT_EN, stall_cycles=3.
- N=32, readdatavalid latency 20 cycles -> outstanding never exceeds 8. Exactly 1024 ram_we. Last ram_addr = 1023.
- start with mx_size=0 -> read never asserted; done pulses 2 cycles after start. start asserted while busy during an N=4 run -> ignored, exactly 16 writes.
- reset asserted mid-ISSUE for N=8 -> read/busy/ram_we go 0 immediately. Later readdatavalid beats cause no ram_we. A new start with N=2 completes normally.
